// File: rtl/elink_wr_arbiter.sv
// Two-requester AXI write-channel arbiter for the elink slave port.
// Round-robin grant with one write transaction in flight at a time.
module elink_wr_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_aresetn,
    input  logic [2*AW-1:0]     up_awaddr,
    input  logic [15:0]         up_awlen,
    input  logic [1:0]          up_awvalid,
    output logic [1:0]          up_awready,
    input  logic [2*DW-1:0]     up_wdata,
    input  logic [2*DW/8-1:0]   up_wstrb,
    input  logic [1:0]          up_wlast,
    input  logic [1:0]          up_wvalid,
    output logic [1:0]          up_wready,
    output logic [3:0]          up_bresp,
    output logic [1:0]          up_bvalid,
    input  logic [1:0]          up_bready,
    output logic [AW-1:0]       dn_awaddr,
    output logic [7:0]          dn_awlen,
    output logic [11:0]         dn_awid,
    output logic                dn_awvalid,
    input  logic                dn_awready,
    output logic [DW-1:0]       dn_wdata,
    output logic [DW/8-1:0]     dn_wstrb,
    output logic                dn_wlast,
    output logic                dn_wvalid,
    input  logic                dn_wready,
    input  logic [11:0]         dn_bid,
    input  logic [1:0]          dn_bresp,
    input  logic                dn_bvalid,
    output logic                dn_bready,
    output logic [1:0]          grant
);

    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic [8:0]  beat_cnt_q, beat_cnt_d;
    logic [7:0]  awlen_q, awlen_d;
    logic        len_err_q, len_err_d;

    logic        owner_sel;
    logic        resp_err;
    logic [1:0]  resp_code;

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            beat_cnt_q   <= 9'd0;
            awlen_q      <= 8'd0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            awlen_q      <= awlen_d;
            len_err_q    <= len_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        awlen_d      = awlen_q;
        len_err_d    = len_err_q;

        up_awready = 2'b00;
        up_wready  = 2'b00;
        up_bresp   = 4'b0000;
        up_bvalid  = 2'b00;
        dn_awaddr  = '0;
        dn_awlen   = 8'd0;
        dn_awid    = 12'd0;
        dn_awvalid = 1'b0;
        dn_wdata   = '0;
        dn_wstrb   = '0;
        dn_wlast   = 1'b0;
        dn_wvalid  = 1'b0;
        dn_bready  = 1'b0;
        grant      = grant_q;

        owner_sel = 1'b0;
        resp_err  = 1'b0;
        resp_code = 2'b00;

        case (state_q)
            IDLE: begin
                if (up_awvalid != 2'b00) begin
                    // Under contention the requester that did not go last wins.
                    if (up_awvalid == 2'b11) owner_sel = ~last_owner_q;
                    else                     owner_sel = up_awvalid[1];
                    owner_d    = owner_sel;
                    grant_d    = owner_sel ? 2'b10 : 2'b01;
                    beat_cnt_d = 9'd0;
                    len_err_d  = 1'b0;
                    state_d    = ADDR;
                end
            end

            ADDR: begin
                dn_awaddr  = owner_q ? up_awaddr[2*AW-1:AW] : up_awaddr[AW-1:0];
                dn_awlen   = owner_q ? up_awlen[15:8] : up_awlen[7:0];
                dn_awid    = {11'd0, owner_q};
                dn_awvalid = up_awvalid[owner_q];
                up_awready[owner_q] = dn_awready;
                if (dn_awvalid && dn_awready) begin
                    awlen_d = dn_awlen;
                    state_d = DATA;
                end
            end

            DATA: begin
                dn_wdata  = owner_q ? up_wdata[2*DW-1:DW] : up_wdata[DW-1:0];
                dn_wstrb  = owner_q ? up_wstrb[2*SW-1:SW] : up_wstrb[SW-1:0];
                dn_wlast  = up_wlast[owner_q];
                dn_wvalid = up_wvalid[owner_q];
                up_wready[owner_q] = dn_wready;
                if (dn_wvalid && dn_wready) begin
                    if (beat_cnt_q != 9'h1FF) beat_cnt_d = beat_cnt_q + 9'd1;
                    if (dn_wlast) begin
                        // beat_cnt_q counts beats before this one, so a correct
                        // burst ends when it equals awlen (i.e. awlen+1 beats).
                        if (beat_cnt_q != {1'b0, awlen_q}) len_err_d = 1'b1;
                        state_d = RESP;
                    end
                end
            end

            RESP: begin
                resp_err  = len_err_q || (dn_bid != {11'd0, owner_q});
                resp_code = resp_err ? 2'b10 : dn_bresp;
                dn_bready = up_bready[owner_q];
                up_bvalid[owner_q] = dn_bvalid;
                if (owner_q) up_bresp[3:2] = resp_code;
                else         up_bresp[1:0] = resp_code;
                if (dn_bvalid && dn_bready) begin
                    last_owner_d = owner_q;
                    grant_d      = 2'b00;
                    state_d      = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Outputs go quiet as soon as reset is asserted, not one edge later.
        if (!s_axi_aresetn) begin
            up_awready = 2'b00;
            up_wready  = 2'b00;
            up_bresp   = 4'b0000;
            up_bvalid  = 2'b00;
            dn_awid    = 12'd0;
            dn_awvalid = 1'b0;
            dn_wvalid  = 1'b0;
            dn_bready  = 1'b0;
            grant      = 2'b00;
        end
    end

endmodule

// File: tb/tb_elink_wr_arbiter.sv
// Directed bench for elink_wr_arbiter: single write, burst, length/ID errors,
// response backpressure, contention ordering and mid-transaction reset.
module tb_elink_wr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;
    logic [2*AW-1:0]   up_awaddr = '0;
    logic [15:0]       up_awlen = '0;
    logic [1:0]        up_awvalid = '0;
    logic [1:0]        up_awready;
    logic [2*DW-1:0]   up_wdata = '0;
    logic [2*DW/8-1:0] up_wstrb = '0;
    logic [1:0]        up_wlast = '0;
    logic [1:0]        up_wvalid = '0;
    logic [1:0]        up_wready;
    logic [3:0]        up_bresp;
    logic [1:0]        up_bvalid;
    logic [1:0]        up_bready = '0;
    logic [AW-1:0]     dn_awaddr;
    logic [7:0]        dn_awlen;
    logic [11:0]       dn_awid;
    logic              dn_awvalid;
    logic              dn_awready = 1'b0;
    logic [DW-1:0]     dn_wdata;
    logic [DW/8-1:0]   dn_wstrb;
    logic              dn_wlast;
    logic              dn_wvalid;
    logic              dn_wready = 1'b0;
    logic [11:0]       dn_bid = '0;
    logic [1:0]        dn_bresp = '0;
    logic              dn_bvalid = 1'b0;
    logic              dn_bready;
    logic [1:0]        grant;

    int total = 0;
    int bad = 0;

    elink_wr_arbiter #(.AW(AW), .DW(DW)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
        .up_awaddr(up_awaddr), .up_awlen(up_awlen), .up_awvalid(up_awvalid),
        .up_awready(up_awready), .up_wdata(up_wdata), .up_wstrb(up_wstrb),
        .up_wlast(up_wlast), .up_wvalid(up_wvalid), .up_wready(up_wready),
        .up_bresp(up_bresp), .up_bvalid(up_bvalid), .up_bready(up_bready),
        .dn_awaddr(dn_awaddr), .dn_awlen(dn_awlen), .dn_awid(dn_awid),
        .dn_awvalid(dn_awvalid), .dn_awready(dn_awready), .dn_wdata(dn_wdata),
        .dn_wstrb(dn_wstrb), .dn_wlast(dn_wlast), .dn_wvalid(dn_wvalid),
        .dn_wready(dn_wready), .dn_bid(dn_bid), .dn_bresp(dn_bresp),
        .dn_bvalid(dn_bvalid), .dn_bready(dn_bready), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        up_awvalid = '0; up_wvalid = '0; up_wlast = '0; up_bready = '0;
        dn_awready = 1'b0; dn_wready = 1'b0; dn_bvalid = 1'b0;
        dn_bid = '0; dn_bresp = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn = 1'b0;
        clr_inputs();
        @(negedge clk);
        #1;
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_dn_awvalid", 64'(dn_awvalid), 64'h0);
        chk("rst_up_awready", 64'(up_awready), 64'h0);
        chk("rst_dn_awid", 64'(dn_awid), 64'h0);
        chk("rst_up_bresp", 64'(up_bresp), 64'h0);
        chk("rst_up_bvalid", 64'(up_bvalid), 64'h0);
        aresetn = 1'b1;
    endtask

    // Entered in IDLE just after the caller raised up_awvalid[r]; returns at the
    // negedge following the response handshake (the arbitration idle cycle).
    task automatic txn(input int r, input int beats, input logic [1:0] exp_resp,
                       input bit keep_aw, input bit toggle, input bit bad_bid,
                       input int hold_b);
        logic [1:0] onehot;
        logic [3:0] exp_bresp;
        onehot = (r == 1) ? 2'b10 : 2'b01;
        exp_bresp = (r == 1) ? {exp_resp, 2'b00} : {2'b00, exp_resp};
        #1;
        chk("idle_grant", 64'(grant), 64'h0);
        @(negedge clk);
        #1;
        chk("addr_grant", 64'(grant), 64'(onehot));
        chk("addr_dn_awvalid", 64'(dn_awvalid), 64'h1);
        chk("addr_dn_awid", 64'(dn_awid), 64'(r));
        chk("addr_dn_awaddr", 64'(dn_awaddr), 64'(up_awaddr[r*AW +: AW]));
        chk("addr_dn_awlen", 64'(dn_awlen), 64'(up_awlen[r*8 +: 8]));
        dn_awready = 1'b1;
        #1;
        chk("addr_up_awready", 64'(up_awready), 64'(onehot));
        @(negedge clk);
        dn_awready = 1'b0;
        if (!keep_aw) up_awvalid[r] = 1'b0;
        for (int b = 0; b < beats; b++) begin
            up_wvalid[r] = 1'b1;
            up_wdata[r*DW +: DW] = 32'hA000_0000 + 32'(b) + (r == 1 ? 32'h0100_0000 : 32'h0);
            up_wstrb[r*4 +: 4] = 4'hF;
            up_wlast[r] = (b == beats - 1);
            if (toggle) begin
                dn_wready = 1'b0;
                #1;
                chk("data_stall_wvalid", 64'(dn_wvalid), 64'h1);
                chk("data_stall_wready", 64'(up_wready), 64'h0);
                @(negedge clk);
            end
            dn_wready = 1'b1;
            #1;
            chk("data_up_wready", 64'(up_wready), 64'(onehot));
            chk("data_dn_wdata", 64'(dn_wdata), 64'(up_wdata[r*DW +: DW]));
            chk("data_dn_wlast", 64'(dn_wlast), 64'(b == beats - 1));
            @(negedge clk);
        end
        up_wvalid = '0; up_wlast = '0; dn_wready = 1'b0;
        dn_bvalid = 1'b1;
        dn_bresp = 2'b00;
        dn_bid = bad_bid ? 12'(1 - r) : 12'(r);
        for (int h = 0; h < hold_b; h++) begin
            up_bready = '0;
            #1;
            chk("hold_dn_bready", 64'(dn_bready), 64'h0);
            chk("hold_grant", 64'(grant), 64'(onehot));
            chk("hold_up_awready", 64'(up_awready), 64'h0);
            @(negedge clk);
        end
        up_bready[r] = 1'b1;
        #1;
        chk("resp_up_bvalid", 64'(up_bvalid), 64'(onehot));
        chk("resp_up_bresp", 64'(up_bresp), 64'(exp_bresp));
        chk("resp_dn_bready", 64'(dn_bready), 64'h1);
        @(negedge clk);
        clr_inputs();
        if (keep_aw) up_awvalid = 2'b11;
        #1;
        chk("post_grant", 64'(grant), 64'h0);
        chk("post_dn_awvalid", 64'(dn_awvalid), 64'h0);
        chk("post_up_bvalid", 64'(up_bvalid), 64'h0);
    endtask

    initial begin
        up_awaddr = {32'h9090_0000, 32'h8080_0000};

        do_reset();

        // Single write from requester 0.
        up_awlen = 16'h0000;
        up_awvalid[0] = 1'b1;
        txn(0, 1, 2'b00, 0, 0, 0, 0);

        // Requester 1, four-beat burst with downstream wready toggling.
        up_awlen = 16'h0300;
        up_awvalid[1] = 1'b1;
        txn(1, 4, 2'b00, 0, 1, 0, 0);

        // Requester 0 declares 4 beats but signals wlast on beat 2.
        up_awlen = 16'h0003;
        up_awvalid[0] = 1'b1;
        txn(0, 2, 2'b10, 0, 0, 0, 0);

        // Response ID that does not name the owner.
        up_awlen = 16'h0000;
        up_awvalid[1] = 1'b1;
        txn(1, 1, 2'b10, 0, 0, 1, 0);

        // Response backpressure with requester 1 waiting.
        up_awvalid = 2'b11;
        txn(0, 1, 2'b00, 0, 0, 0, 10);
        up_awvalid[1] = 1'b1;
        txn(1, 1, 2'b00, 0, 0, 0, 0);

        // Continuous contention after reset: 0,1,0,1,...
        do_reset();
        up_awlen = 16'h0000;
        up_awvalid = 2'b11;
        for (int k = 0; k < 8; k++) txn(k % 2, 1, 2'b00, 1, 0, 0, 0);
        up_awvalid = 2'b00;

        // Reset during DATA after the first beat.
        @(negedge clk);
        up_awlen = 16'h0003;
        up_awvalid[0] = 1'b1;
        @(negedge clk);
        dn_awready = 1'b1;
        @(negedge clk);
        dn_awready = 1'b0;
        up_awvalid = '0;
        up_wvalid[0] = 1'b1;
        up_wlast[0] = 1'b0;
        dn_wready = 1'b1;
        #1;
        chk("mid_up_wready", 64'(up_wready), 64'h1);
        @(negedge clk);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_dn_wvalid", 64'(dn_wvalid), 64'h0);
        chk("mid_rst_up_wready", 64'(up_wready), 64'h0);
        chk("mid_rst_grant", 64'(grant), 64'h0);
        @(negedge clk);
        aresetn = 1'b1;
        clr_inputs();
        dn_bvalid = 1'b1;
        #1;
        chk("after_rst_up_bvalid", 64'(up_bvalid), 64'h0);
        chk("after_rst_dn_bready", 64'(dn_bready), 64'h0);
        chk("after_rst_grant", 64'(grant), 64'h0);
        dn_bvalid = 1'b0;
        up_awlen = 16'h0000;
        up_awvalid[1] = 1'b1;
        txn(1, 1, 2'b00, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/elink_wr_arbiter.md
ELINK_WR_ARBITER -- requirements
Module: elink_wr_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, write-data width; strobe width = DW/8.
REQ-003 s_axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-004 s_axi_aresetn  in  1  reset, synchronous, active-low.
REQ-005 up_awaddr  in  2*AW  per-requester write address; slice i = requester i.
REQ-006 up_awlen  in  2*8  per-requester burst length minus one.
REQ-007 up_awvalid  in  2  per-requester address valid.
REQ-008 up_awready  out  2  per-requester address accept.
REQ-009 up_wdata  in  2*DW  per-requester write data.
REQ-010 up_wstrb  in  2*DW/8  per-requester byte strobes.
REQ-011 up_wlast  in  2  per-requester last beat.
REQ-012 up_wvalid  in  2  per-requester data valid.
REQ-013 up_wready  out  2  per-requester data accept.
REQ-014 up_bresp  out  2*2  per-requester write response.
REQ-015 up_bvalid  out  2  per-requester response valid.
REQ-016 up_bready  in  2  per-requester response accept.
REQ-017 dn_awaddr / dn_awlen  out  AW / 8  address and length to elink write slave port.
REQ-018 dn_awid  out  12  transaction ID; bit 0 = granted requester, bits 11:1 = 0.
REQ-019 dn_awvalid out 1 / dn_awready in 1  downstream address handshake.
REQ-020 dn_wdata out DW / dn_wstrb out DW/8 / dn_wlast out 1  downstream write beat.
REQ-021 dn_wvalid out 1 / dn_wready in 1  downstream data handshake.
REQ-022 dn_bid in 12 / dn_bresp in 2 / dn_bvalid in 1 / dn_bready out 1  downstream response.
REQ-023 grant  out  2  one-hot current owner; 0 when idle.

Function
REQ-024 SHALL implement FSM IDLE -> ADDR -> DATA -> RESP -> IDLE; one transaction outstanding at a time.
REQ-025 IDLE: if any up_awvalid set, SHALL select owner by round-robin (priority to requester other than last_owner), register grant, go ADDR next cycle; no request -> stay IDLE, grant=0.
REQ-026 ADDR: dn_aw* SHALL mirror owner's up_aw* (registered owner mux), dn_awvalid = owner up_awvalid; up_awready[owner] = dn_awready, other = 0; on handshake go DATA.
REQ-027 DATA: dn_w* SHALL mirror owner's up_w*; up_wready[owner] = dn_wready, other = 0; beat counter counts handshakes; on handshake with dn_wlast=1 go RESP.
REQ-028 Beat count SHALL be checked: wlast on beat != awlen+1 sets sticky internal error flag and forces owner's up_bresp = 2'b10 (SLVERR) for that transaction; transaction still completes.
REQ-029 RESP: dn_bready = up_bready[owner]; up_bvalid[owner] = dn_bvalid; up_bresp[owner] = dn_bresp unless REQ-028 override; on handshake update last_owner, clear grant, go IDLE.
REQ-030 dn_bid bit 0 not matching owner SHALL force SLVERR to owner (response still consumed).
REQ-031 Non-owner up_awready, up_wready, up_bvalid SHALL be 0 in every state.
REQ-032 Both requesters asserting in same IDLE cycle: SHALL alternate; consecutive transactions under continuous contention go 0,1,0,1... starting with 0 after reset.
REQ-033 Requester dropping up_awvalid before handshake is a protocol violation; arbiter SHALL hold grant until handshake (no re-arbitration mid-transaction).
REQ-034 Arbitration overhead SHALL be exactly one cycle (IDLE) between RESP handshake and next dn_awvalid.
REQ-035 dn_awlen up to 255 SHALL be supported; beat counter 9 bits, no wrap.

Reset
REQ-036 While s_axi_aresetn=0 at clock edge: state=IDLE, grant=0, last_owner=1, counter=0, error flag=0.
REQ-037 During/after reset all *valid and *ready outputs SHALL be 0; dn_awid=0, up_bresp=0.
REQ-038 Reset mid-transaction SHALL abandon it immediately; no pending response forwarded afterward.

Verification
REQ-039 Single write: r0 awaddr=0x80800000 awlen=0, one beat wdata=0xDEADBEEF, dn_bresp=0 -> dn_awid=0, one dn beat, r0 bvalid with OKAY, grant 01 then 00.
REQ-040 Contention: both requesters issue 4 writes back-to-back -> order r0,r1,r0,r1,r0,r1,r0,r1; one idle cycle between transactions.
REQ-041 Burst: r1 awlen=3, four beats with dn_wready toggling every cycle -> exactly 4 beats pass, dn_awid=1, wlast on beat 4, OKAY.
REQ-042 Length error: r0 awlen=3, wlast on beat 2 -> transaction ends after 2 beats, r0 bresp=2'b10.
REQ-043 Reset mid-DATA: drop s_axi_aresetn for one cycle after beat 1 -> all valids/readys 0, grant 0, following r1 request served normally.
REQ-044 Backpressure: up_bready[0]=0 for 10 cycles with dn_bvalid=1 -> dn_bready=0, no new grant until accepted.
